name_line_parser: RTL and testbench
===================================

// Module: name_line_parser
// PURPOSE
//  Byte-stream tokenizer directly upstream of the FASTQ name-line compressor.
//  - Accepts one ASCII character per cycle of a FASTQ name line,
//    e.g. "@HISEQ-MFG:461:C70PYACXX:8:1101:18260:2391 1:N:0:GCCAAT\n".
//  - Splits the line on ':' into the ten 128-bit right-justified fields the compressor consumes.
//  - Presents all fields together with a one-cycle line_valid strobe.
// PARAMETERS
//  FIELD_W   128    width of each field register; MAX_CH = FIELD_W/8 = 16 chars
//  SEP       8'h3A  field separator (':')
//  EOL       8'h0A  line terminator ('\n')
// PORTS
//  clk            in   1    system clock, all state on rising edge
//  rst_n          in   1    asynchronous active-low reset
//  in_data        in   8    ASCII character
//  in_valid       in   1    in_data valid
//  in_ready       out  1    character accepted when in_valid & in_ready
//  Inst_field     out  128  field 0 (instrument incl. '@')
//  Run_field      out  128  field 1
//  Flow_field     out  128  field 2
//  Lane_field     out  128  field 3
//  Tile_field     out  128  field 4
//  Xpos_field     out  128  field 5
//  Ypos_r_field   out  128  field 6 (y position, space, read number)
//  Filtered_field out  128  field 7
//  Cntl_num_field out  128  field 8
//  Index_field    out  128  field 9
//  line_valid     out  1    1-cycle strobe: all ten fields updated
//  line_err       out  1    1-cycle strobe: line malformed, fields NOT updated
//  line_cnt       out  16   count of good lines, wraps 0xFFFF->0
// BEHAVIOUR
//  - Reset: all fields 0, line_valid=0, line_err=0, line_cnt=0, state=COLLECT, in_ready=1.
//  - Field packing: each accepted char -> work = {work[FIELD_W-9:0], char]}.
//    - Last char lands in [7:0]; unused upper bytes are 0, matching a Verilog string literal.
//    - Empty field = all 0.
//  - Separate working bank (10 x FIELD_W) with field index fidx (0..9) and char count ccnt (0..MAX_CH).
//  - Output regs change only on commit, so the compressor sees stable fields between strobes.
//  - State COLLECT (in_ready=1):
//    - char==SEP, fidx<9: fidx++, ccnt=0, next work field cleared.
//    - char==SEP, fidx==9: bad=1, go SKIP.
//    - char==EOL: go COMMIT.
//    - Any other char (incl. space), ccnt<MAX_CH: shift into work[fidx], ccnt++.
//    - Any other char, ccnt==MAX_CH: char dropped (first 16 chars kept), bad=1, stay in COLLECT.
//  - State SKIP (in_ready=1): discard chars until EOL, then go COMMIT.
//  - State COMMIT (in_ready=0, exactly 1 cycle):
//    - If !bad && fidx==9: copy work->outputs, line_valid=1, line_cnt++.
//    - Otherwise: line_err=1, outputs held.
//    - Then clear bad/fidx/ccnt/work and return to COLLECT.
//  - Latency: line_valid asserts 2 cycles after the EOL handshake edge (1 edge to COMMIT, strobe
//    registered). Next char is accepted the cycle after COMMIT.
//  - in_valid=0 stalls: no state change. in_ready is a registered function of state only.
//  - Blank line (EOL with fidx==0) is an error: fewer than 10 fields.
//  - rst_n low mid-line: partial line discarded, all regs return to reset values asynchronously.
// CONFIGURATION
//  NAME_CR_STRIP_EN defined:
//    - 8'h0D accepted and discarded in COLLECT/SKIP, so CRLF input yields identical fields to LF.
//  NAME_CR_STRIP_EN undefined:
//    - 8'h0D is an ordinary char, stored in the current field.
// TESTING
//  1 Reset, then stream the example line above -> line_valid once.
//    Inst_field=="@HISEQ-MFG", Ypos_r_field=="2391 1", Index_field=="GCCAAT", line_cnt=1.
//  2 Same line with in_valid toggled every other cycle -> identical fields.
//    line_valid 2 cycles after the EOL handshake; in_ready=0 for exactly the COMMIT cycle.
//  3 "A:B:C\n" -> line_err=1, line_valid=0, outputs keep test-1 values.
//    Next good line parses correctly.
//  4 Field 1 = 20 chars "00000000001111111111" -> line_err=1.
//    Then line with 11 fields (extra ":X") -> line_err=1, line_cnt unchanged.
//  5 Line "0:0:0:0:0:0:0:0:9:0\r\n":
//    - With NAME_CR_STRIP_EN: Index_field==128'h30.
//    - Without: Index_field==128'h300D.
//  6 Assert rst_n low after 12 chars of a line, release, send full line.
//    -> single line_valid, fields equal test 1, line_cnt=1.

Source files
------------

// File: rtl/name_line_parser_if.sv
// Character stream in, ten right-justified name-line fields plus line strobes out.
interface name_line_parser_if #(
  parameter int FIELD_W = 128
);
  logic [7:0]         in_data;
  logic               in_valid;
  logic               in_ready;
  logic [FIELD_W-1:0] Inst_field;
  logic [FIELD_W-1:0] Run_field;
  logic [FIELD_W-1:0] Flow_field;
  logic [FIELD_W-1:0] Lane_field;
  logic [FIELD_W-1:0] Tile_field;
  logic [FIELD_W-1:0] Xpos_field;
  logic [FIELD_W-1:0] Ypos_r_field;
  logic [FIELD_W-1:0] Filtered_field;
  logic [FIELD_W-1:0] Cntl_num_field;
  logic [FIELD_W-1:0] Index_field;
  logic               line_valid;
  logic               line_err;
  logic [15:0]        line_cnt;

  modport master (
    output in_data, in_valid,
    input  in_ready, Inst_field, Run_field, Flow_field, Lane_field, Tile_field,
           Xpos_field, Ypos_r_field, Filtered_field, Cntl_num_field, Index_field,
           line_valid, line_err, line_cnt
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, Inst_field, Run_field, Flow_field, Lane_field, Tile_field,
           Xpos_field, Ypos_r_field, Filtered_field, Cntl_num_field, Index_field,
           line_valid, line_err, line_cnt
  );
endinterface

// File: rtl/name_line_parser.sv
// FASTQ name-line tokenizer: ':'-split into 10 fields, strobe 2 cycles after EOL; in_ready low
// only in the single COMMIT cycle. NAME_CR_STRIP_EN: discard 8'h0D instead of storing it.
module name_line_parser #(
  parameter int         FIELD_W = 128,
  parameter logic [7:0] SEP     = 8'h3A,
  parameter logic [7:0] EOL     = 8'h0A
) (
  input logic          clk,
  input logic          rst_n,
  name_line_parser_if.slave io_bus
);

  localparam int MAX_CH = FIELD_W / 8;
  localparam int CW     = $clog2(MAX_CH + 1);

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_SKIP    = 2'd1;
  localparam logic [1:0] ST_COMMIT  = 2'd2;

  logic [1:0]         r_state;
  logic               r_ready;
  logic [FIELD_W-1:0] r_work [10];
  logic [FIELD_W-1:0] r_out  [10];
  logic [3:0]         r_fidx;
  logic [CW-1:0]      r_ccnt;
  logic               r_bad;
  logic               r_line_valid;
  logic               r_line_err;
  logic [15:0]        r_line_cnt;

  logic w_acc;
  logic w_drop_cr;

  assign w_acc = io_bus.in_valid & r_ready;

`ifdef NAME_CR_STRIP_EN
  assign w_drop_cr = (io_bus.in_data == 8'h0D);
`else
  assign w_drop_cr = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_COLLECT;
      r_ready      <= 1'b1;
      r_fidx       <= '0;
      r_ccnt       <= '0;
      r_bad        <= 1'b0;
      r_line_valid <= 1'b0;
      r_line_err   <= 1'b0;
      r_line_cnt   <= '0;
      for (int i = 0; i < 10; i++) begin
        r_work[i] <= '0;
        r_out[i]  <= '0;
      end
    end else begin
      r_line_valid <= 1'b0;
      r_line_err   <= 1'b0;
      case (r_state)
        ST_COLLECT: begin
          if (w_acc) begin
            if (io_bus.in_data == EOL) begin
              r_state <= ST_COMMIT;
              r_ready <= 1'b0;
            end else if (w_drop_cr) begin
              r_state <= ST_COLLECT;
            end else if (io_bus.in_data == SEP) begin
              if (r_fidx < 4'd9) begin
                r_fidx                <= r_fidx + 4'd1;
                r_ccnt                <= '0;
                r_work[r_fidx + 4'd1] <= '0;
              end else begin
                r_bad   <= 1'b1;
                r_state <= ST_SKIP;
              end
            end else if (r_ccnt != CW'(MAX_CH)) begin
              r_work[r_fidx] <= {r_work[r_fidx][FIELD_W-9:0], io_bus.in_data};
              r_ccnt         <= r_ccnt + CW'(1);
            end else begin
              // overlong field: keep the first MAX_CH chars, flag the line
              r_bad <= 1'b1;
            end
          end
        end
        ST_SKIP: begin
          if (w_acc && io_bus.in_data == EOL) begin
            r_state <= ST_COMMIT;
            r_ready <= 1'b0;
          end
        end
        ST_COMMIT: begin
          if (!r_bad && r_fidx == 4'd9) begin
            for (int i = 0; i < 10; i++) r_out[i] <= r_work[i];
            r_line_valid <= 1'b1;
            r_line_cnt   <= r_line_cnt + 16'd1;
          end else begin
            r_line_err <= 1'b1;
          end
          r_bad   <= 1'b0;
          r_fidx  <= '0;
          r_ccnt  <= '0;
          for (int i = 0; i < 10; i++) r_work[i] <= '0;
          r_state <= ST_COLLECT;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_COLLECT;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign io_bus.in_ready       = r_ready;
  assign io_bus.Inst_field     = r_out[0];
  assign io_bus.Run_field      = r_out[1];
  assign io_bus.Flow_field     = r_out[2];
  assign io_bus.Lane_field     = r_out[3];
  assign io_bus.Tile_field     = r_out[4];
  assign io_bus.Xpos_field     = r_out[5];
  assign io_bus.Ypos_r_field   = r_out[6];
  assign io_bus.Filtered_field = r_out[7];
  assign io_bus.Cntl_num_field = r_out[8];
  assign io_bus.Index_field    = r_out[9];
  assign io_bus.line_valid     = r_line_valid;
  assign io_bus.line_err       = r_line_err;
  assign io_bus.line_cnt       = r_line_cnt;

endmodule

// File: tb/tb_name_line_parser.sv
// Random and directed name lines against a split-on-':' reference model of the tokenizer.
module tb_name_line_parser;
  localparam int FW = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  name_line_parser_if #(.FIELD_W(FW)) bus();

  name_line_parser dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus.slave)
  );

  typedef struct packed {
    logic            good;
    logic [9:0][FW-1:0] f;
  } exp_t;

  exp_t               exp_q[$];
  exp_t               mon_e;
  logic [9:0][FW-1:0] m_f;
  logic [15:0]        m_cnt;
  logic [7:0]         cur_line[$];
  int                 n_chk = 0;
  int                 n_err = 0;
  logic [9:0][FW-1:0] dut_f;

  assign dut_f = {bus.Index_field, bus.Cntl_num_field, bus.Filtered_field, bus.Ypos_r_field,
                  bus.Xpos_field, bus.Tile_field, bus.Lane_field, bus.Flow_field,
                  bus.Run_field, bus.Inst_field};

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: split the line on ':' into strings, then judge and right-justify them.
  function automatic exp_t model_line();
    exp_t       e;
    logic [7:0] body[$];
    int         starts[$];
    int         ends[$];
    int         maxlen;
    logic [7:0] c;
    e = '0;
    foreach (cur_line[i]) begin
      if (cur_line[i] == 8'h0A) break;
`ifdef NAME_CR_STRIP_EN
      if (cur_line[i] == 8'h0D) continue;
`endif
      body.push_back(cur_line[i]);
    end
    starts.push_back(0);
    foreach (body[i]) begin
      if (body[i] == 8'h3A) begin
        ends.push_back(i);
        starts.push_back(i + 1);
      end
    end
    ends.push_back(body.size());
    maxlen = 0;
    foreach (starts[k]) if (ends[k] - starts[k] > maxlen) maxlen = ends[k] - starts[k];
    e.good = (starts.size() == 10) && (maxlen <= FW / 8);
    if (e.good) begin
      for (int k = 0; k < 10; k++) begin
        for (int j = starts[k]; j < ends[k]; j++) begin
          c = body[j];
          e.f[k] = (e.f[k] << 8) | {{(FW-8){1'b0}}, c};
        end
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      m_f   = '0;
      m_cnt = '0;
    end else begin
      if (bus.line_valid || bus.line_err) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_strobe: got valid=%0b err=%0b expected none",
                   bus.line_valid, bus.line_err);
        end else begin
          mon_e = exp_q.pop_front();
          check("strobe_kind", {126'd0, bus.line_valid, bus.line_err},
                {126'd0, mon_e.good, ~mon_e.good});
          if (mon_e.good) begin
            m_f   = mon_e.f;
            m_cnt = m_cnt + 16'd1;
          end
        end
      end
      n_chk++;
      if (dut_f !== m_f) begin
        n_err++;
        for (int k = 0; k < 10; k++) begin
          if (dut_f[k] !== m_f[k]) begin
            $display("FAIL field%0d: got %h expected %h", k, dut_f[k], m_f[k]);
            break;
          end
        end
      end
      check("line_cnt", {112'd0, bus.line_cnt}, {112'd0, m_cnt});
    end
  end

  task automatic set_line(input string s, input bit add_eol);
    cur_line.delete();
    for (int i = 0; i < s.len(); i++) cur_line.push_back(s[i]);
    if (add_eol) cur_line.push_back(8'h0A);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    repeat (gap) begin
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!bus.in_ready) begin
      n_chk++;
      n_err++;
      $display("FAIL in_ready_timeout: got 0 expected 1 within 50 cycles");
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // mode 0: back-to-back, 1: valid every other cycle, 2: random gaps
  task automatic send_line(input int mode, output logic got_v, output logic got_e);
    int gap;
    exp_q.push_back(model_line());
    foreach (cur_line[i]) begin
      gap = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2));
      send_byte(cur_line[i], gap);
    end
    check("ready_low_in_commit", {127'd0, bus.in_ready}, '0);
    check("no_early_strobe", {127'd0, bus.line_valid | bus.line_err}, '0);
    @(posedge clk); #1;
    got_v = bus.line_valid;
    got_e = bus.line_err;
    check("strobe_latency", {127'd0, got_v | got_e}, {127'd0, 1'b1});
    check("ready_after_commit", {127'd0, bus.in_ready}, {127'd0, 1'b1});
  endtask

  task automatic gen_line();
    int         kind, nf, bad_fld, len;
    logic [7:0] c;
    cur_line.delete();
    kind    = int'($urandom_range(0, 9));
    nf      = (kind == 0) ? int'($urandom_range(1, 9)) : (kind == 1) ? 11 : 10;
    bad_fld = (kind == 2) ? int'($urandom_range(0, 9)) : -1;
    for (int f = 0; f < nf; f++) begin
      if (f > 0) cur_line.push_back(8'h3A);
      len = (f == bad_fld) ? int'($urandom_range(17, 20)) : int'($urandom_range(0, 16));
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 40) == 0) c = 8'h0D;
        else begin
          c = 8'($urandom_range(32, 126));
          if (c == 8'h3A) c = 8'h5F;
        end
        cur_line.push_back(c);
      end
    end
    cur_line.push_back(8'h0A);
  endtask

  task automatic check_reset_values();
    check("rst_fields", (dut_f == '0) ? 128'd0 : 128'd1, 128'd0);
    check("rst_line_cnt", {112'd0, bus.line_cnt}, '0);
    check("rst_in_ready", {127'd0, bus.in_ready}, {127'd0, 1'b1});
    check("rst_strobes", {126'd0, bus.line_valid, bus.line_err}, '0);
  endtask

  localparam string EX = "@HISEQ-MFG:461:C70PYACXX:8:1101:18260:2391 1:N:0:GCCAAT";

  logic [FW-1:0] lit_inst, lit_ypos, lit_idx;
  logic          gv, ge;

  initial begin
    lit_inst = "@HISEQ-MFG";
    lit_ypos = "2391 1";
    lit_idx  = "GCCAAT";
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    rst_n = 1'b1;
    @(posedge clk); #1;

    set_line(EX, 1'b1);
    send_line(0, gv, ge);
    check("t1_valid", {127'd0, gv}, {127'd0, 1'b1});
    check("t1_inst", bus.Inst_field, lit_inst);
    check("t1_ypos", bus.Ypos_r_field, lit_ypos);
    check("t1_index", bus.Index_field, lit_idx);
    check("t1_cnt", {112'd0, bus.line_cnt}, 128'd1);

    send_line(1, gv, ge);
    check("t2_valid", {127'd0, gv}, {127'd0, 1'b1});
    check("t2_inst", bus.Inst_field, lit_inst);
    check("t2_index", bus.Index_field, lit_idx);

    set_line("A:B:C", 1'b1);
    send_line(0, gv, ge);
    check("t3_err", {126'd0, gv, ge}, 128'd1);
    check("t3_inst_held", bus.Inst_field, lit_inst);
    check("t3_cnt_held", {112'd0, bus.line_cnt}, 128'd2);
    set_line(EX, 1'b1);
    send_line(2, gv, ge);
    check("t3_recover_cnt", {112'd0, bus.line_cnt}, 128'd3);

    set_line("@HISEQ-MFG:00000000001111111111:C70PYACXX:8:1101:18260:2391 1:N:0:GCCAAT", 1'b1);
    send_line(0, gv, ge);
    check("t4_long_err", {126'd0, gv, ge}, 128'd1);
    set_line({EX, ":X"}, 1'b1);
    send_line(0, gv, ge);
    check("t4_extra_err", {126'd0, gv, ge}, 128'd1);
    check("t4_cnt_held", {112'd0, bus.line_cnt}, 128'd3);

    set_line("0:0:0:0:0:0:0:0:9:0", 1'b0);
    cur_line.push_back(8'h0D);
    cur_line.push_back(8'h0A);
    send_line(0, gv, ge);
`ifdef NAME_CR_STRIP_EN
    check("t5_index", bus.Index_field, 128'h30);
`else
    check("t5_index", bus.Index_field, 128'h300D);
`endif

    set_line("", 1'b1);
    send_line(0, gv, ge);
    check("blank_err", {126'd0, gv, ge}, 128'd1);

    for (int n = 0; n < 40; n++) begin
      gen_line();
      send_line(2, gv, ge);
    end

    set_line(EX, 1'b1);
    for (int i = 0; i < 12; i++) send_byte(cur_line[i], 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_values();
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_line(0, gv, ge);
    check("t6_valid", {127'd0, gv}, {127'd0, 1'b1});
    check("t6_inst", bus.Inst_field, lit_inst);
    check("t6_ypos", bus.Ypos_r_field, lit_ypos);
    check("t6_cnt", {112'd0, bus.line_cnt}, 128'd1);

    repeat (3) @(posedge clk);
    #1;
    check("pending_strobes", exp_q.size(), 128'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
